phy_tx_serializer: RTL and testbench

- Transmit-side byte serializer directly upstream of the receive PHY.
- Takes one byte per 8-cycle frame from the transmit lane mux and drives a single serial line at the bit rate (clk_32f domain), MSB first.
- After reset it emits a comma (0xBC) preamble so the receiver can align its byte boundary and go active.
- It then sends payload bytes when valid, and idle symbols (0x7C) otherwise.

---
 rtl/phy_pkg.sv | 18 +
 rtl/phy_tx_piso.sv | 37 +++
 rtl/phy_tx_serializer.sv | 92 +++++++++
 tb/tb_phy_tx_serializer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// phy_pkg: symbols, FSM encoding and framing constants shared by the PHY
// transmit serializer and the receive aligner.
//   PHY_FRAME_BITS : bits per serial frame (one byte)
//   PHY_COMMA      : alignment symbol sent during the sync preamble
//   PHY_IDLE       : filler symbol sent when no payload is valid
//   phyState_t     : link state, SYNC=0 / RUN=1
package phy_pkg;

    localparam int unsigned PHY_FRAME_BITS = 8;
    localparam logic [7:0]  PHY_COMMA      = 8'hBC;
    localparam logic [7:0]  PHY_IDLE       = 8'h7C;

    typedef enum logic {
        StSync = 1'b0,
        StRun  = 1'b1
    } phyState_t;

endpackage

// File: rtl/phy_tx_piso.sv
// phy_tx_piso: 8-bit parallel-in serial-out shift register, MSB first.
//   clk       : bit-rate clock
//   reset     : asynchronous active-low reset (shift register <= RESET_VAL)
//   load      : parallel load strobe, asserted in the last bit cycle of a frame
//   loadData  : byte loaded at the load edge
//   serialOut : registered MSB of the shift register
module phy_tx_piso
    import phy_pkg::*;
#(
    parameter logic [PHY_FRAME_BITS-1:0] RESET_VAL = PHY_COMMA
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [PHY_FRAME_BITS-1:0] loadData,
    output logic                      serialOut
);

    logic [PHY_FRAME_BITS-1:0] shiftReg;

    // The load edge still drives out the current LSB (now at the MSB position)
    // while the next byte enters, so consecutive frames have no gap bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftReg  <= RESET_VAL;
            serialOut <= 1'b0;
        end else begin
            serialOut <= shiftReg[PHY_FRAME_BITS-1];
            if (load) begin
                shiftReg <= loadData;
            end else begin
                shiftReg <= {shiftReg[PHY_FRAME_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: transmit byte serializer feeding the receive PHY.
// After reset it sends SYNC_COMMAS comma frames, then enters RUN and sends
// one payload byte per 8-cycle frame when valid, idle symbols otherwise.
//   clk            : bit-rate clock (clk_32f)
//   reset          : asynchronous active-low reset
//   dataIn         : payload byte, sampled when loadReq_cond=1
//   validIn        : dataIn qualifier, sampled with dataIn
//   serialOut_cond : registered serial stream, MSB first
//   loadReq_cond   : last bit cycle of a frame whose successor takes upstream data
//   active_cond    : high while in RUN
//   txCount_cond   : (TX_BYTE_COUNT_EN only) count of payload bytes loaded, wraps
// Optional feature macro: TX_BYTE_COUNT_EN
module phy_tx_serializer
    import phy_pkg::*;
#(
    parameter int unsigned               SYNC_COMMAS = 4,
    parameter logic [PHY_FRAME_BITS-1:0] COMMA       = PHY_COMMA,
    parameter logic [PHY_FRAME_BITS-1:0] IDLE        = PHY_IDLE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PHY_FRAME_BITS-1:0] dataIn,
    input  logic                      validIn,
    output logic                      serialOut_cond,
    output logic                      loadReq_cond,
    output logic                      active_cond
`ifdef TX_BYTE_COUNT_EN
    ,
    output logic [15:0]               txCount_cond
`endif
);

    localparam int unsigned CntW = $clog2(PHY_FRAME_BITS);

    phyState_t                 state;
    logic [CntW-1:0]           bitCnt;
    logic [3:0]                commaCnt;
    logic                      frameEnd;
    logic                      lastComma;
    logic [PHY_FRAME_BITS-1:0] nextSym;

    assign frameEnd     = (bitCnt == CntW'(PHY_FRAME_BITS - 1));
    assign lastComma    = (commaCnt == 4'(SYNC_COMMAS - 1));
    assign loadReq_cond = frameEnd && ((state == StRun) || lastComma);

    // validIn gates dataIn so an undriven bus never reaches the line.
    always_comb begin
        nextSym = COMMA;
        if (loadReq_cond) begin
            nextSym = validIn ? dataIn : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StSync;
            bitCnt      <= '0;
            commaCnt    <= '0;
            active_cond <= 1'b0;
        end else begin
            bitCnt <= bitCnt + 1'b1;
            if (frameEnd && (state == StSync)) begin
                commaCnt <= commaCnt + 1'b1;
                if (lastComma) begin
                    state       <= StRun;
                    active_cond <= 1'b1;
                end
            end
        end
    end

`ifdef TX_BYTE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txCount_cond <= '0;
        end else if (loadReq_cond && validIn) begin
            txCount_cond <= txCount_cond + 16'd1;
        end
    end
`endif

    phy_tx_piso #(
        .RESET_VAL(COMMA)
    ) uPiso (
        .clk      (clk),
        .reset    (reset),
        .load     (frameEnd),
        .loadData (nextSym),
        .serialOut(serialOut_cond)
    );

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Directed bench for phy_tx_serializer with the default SYNC_COMMAS=4.
module tb_phy_tx_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] dataIn;
    logic       validIn;
    logic       serialOut;
    logic       loadReq;
    logic       active;
`ifdef TX_BYTE_COUNT_EN
    logic [15:0] txCount;
`endif

    int total = 0;
    int bad   = 0;

    phy_tx_serializer dut (
        .clk           (clk),
        .reset         (reset),
        .dataIn        (dataIn),
        .validIn       (validIn),
        .serialOut_cond(serialOut),
        .loadReq_cond  (loadReq),
        .active_cond   (active)
`ifdef TX_BYTE_COUNT_EN
        ,
        .txCount_cond  (txCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Collects one 8-bit frame. Inputs offered here are what the frame-end edge
    // samples for the next frame; they are deliberately scrambled mid-frame.
    task automatic runFrame(input logic [7:0] d, input logic v,
                            output logic [7:0] got, output logic ldSeen,
                            output logic ldStray);
        got     = '0;
        ldSeen  = 1'b0;
        ldStray = 1'b0;
        dataIn  = v ? d : 8'hxx;
        validIn = v;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            got = {got[6:0], serialOut};
            if (i == 6) ldSeen = loadReq;
            else if (loadReq) ldStray = 1'b1;
            if (i == 1) begin
                dataIn  = ~d;
                validIn = ~v;
            end
            if (i == 4) begin
                dataIn  = v ? d : 8'hxx;
                validIn = v;
            end
        end
    endtask

    // Checks the comma preamble right after reset release.
    task automatic checkPreamble(input string tag);
        logic [7:0] got;
        logic       ld;
        logic       stray;
        for (int f = 0; f < 4; f++) begin
            runFrame(8'h00, 1'b0, got, ld, stray);
            checkVal({tag, "_comma"}, {24'd0, got}, 32'hBC);
            checkVal({tag, "_ldreq"}, {31'd0, ld}, (f == 3) ? 32'd1 : 32'd0);
            checkVal({tag, "_stray"}, {31'd0, stray}, 32'd0);
            checkVal({tag, "_active"}, {31'd0, active}, (f == 3) ? 32'd1 : 32'd0);
        end
    endtask

    logic [7:0] got;
    logic       ld;
    logic       stray;

    // Each entry: byte offered during this frame, its valid, expected frame content
    logic [7:0] vecData  [8] = '{8'hA5, 8'h00, 8'h01, 8'h80, 8'hFF, 8'hBC, 8'h00, 8'h5A};
    logic       vecValid [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] vecExp   [8] = '{8'h7C, 8'hA5, 8'h7C, 8'h01, 8'h80, 8'hFF, 8'hBC, 8'h7C};

    initial begin
        reset   = 1'b0;
        dataIn  = 8'h00;
        validIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_serial", {31'd0, serialOut}, 32'd0);
        checkVal("rst_active", {31'd0, active}, 32'd0);
        checkVal("rst_ldreq", {31'd0, loadReq}, 32'd0);
`ifdef TX_BYTE_COUNT_EN
        checkVal("rst_count", {16'd0, txCount}, 32'd0);
`endif
        reset = 1'b1;

        checkPreamble("pre");

        for (int k = 0; k < 8; k++) begin
            runFrame(vecData[k], vecValid[k], got, ld, stray);
            checkVal($sformatf("run%0d_data", k), {24'd0, got}, {24'd0, vecExp[k]});
            checkVal($sformatf("run%0d_ldreq", k), {31'd0, ld}, 32'd1);
            checkVal($sformatf("run%0d_active", k), {31'd0, active}, 32'd1);
        end
`ifdef TX_BYTE_COUNT_EN
        // A5, 01, 80, FF, BC, 5A loaded; idles excluded
        checkVal("count_payload", {16'd0, txCount}, 32'd6);
`endif

        // 0x5A frame is on the line; abort it after its top three bits
        got = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = {got[6:0], serialOut};
        end
        checkVal("abort_prefix", {24'd0, got}, 32'h2);
        reset = 1'b0;
        #1;
        checkVal("abort_serial", {31'd0, serialOut}, 32'd0);
        checkVal("abort_active", {31'd0, active}, 32'd0);
        checkVal("abort_ldreq", {31'd0, loadReq}, 32'd0);
`ifdef TX_BYTE_COUNT_EN
        checkVal("abort_count", {16'd0, txCount}, 32'd0);
`endif
        @(posedge clk);
        #1;
        checkVal("abort_hold_serial", {31'd0, serialOut}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        checkPreamble("re");
        runFrame(8'h3C, 1'b1, got, ld, stray);
        checkVal("re_idle", {24'd0, got}, 32'h7C);
        runFrame(8'h00, 1'b0, got, ld, stray);
        checkVal("re_data", {24'd0, got}, 32'h3C);
`ifdef TX_BYTE_COUNT_EN
        checkVal("re_count", {16'd0, txCount}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
